// File: rtl/pipe_pkg.sv
// Shared types and helpers for the elastic pipeline stage.
// Occupancy encoding for the skid FSM and the counter saturation limit.
package pipe_pkg;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  // All-ones value of a w-bit counter, returned in a 64-bit container.
  function automatic logic [63:0] sat_limit(input int unsigned w);
    if (w >= 64)
      sat_limit = '1;
    else
      sat_limit = (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: +1 per cycle with inc high, sticks at all-ones.
// Synchronous active-high reset clears it; result visible the cycle after the event.
module sat_counter
  import pipe_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(sat_limit(CNT_W));

  always_ff @(posedge clk) begin
    if (reset)
      cnt <= '0;
    else if (inc && (cnt != CNT_MAX))
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/pipe_stage.sv
// Elastic valid/ready pipeline register, 1-cycle latency, with flush and optional skid entry.
// SKID=1 registers in_ready (absorbs one beat under backpressure); SKID=0 passes ready through.
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SKID  = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);

  logic in_xfer;
  logic out_xfer;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  generate
    if (SKID != 0) begin : g_skid
      occ_e             state;
      logic [WIDTH-1:0] main_q;
      logic [WIDTH-1:0] skid_q;

      assign out_valid = (state != OCC_EMPTY);
      assign out_data  = main_q;
      assign in_ready  = (state != OCC_FULL) | flush;

      // main_q is the output register; skid_q only holds the beat that arrived while stalled.
      always_ff @(posedge clk) begin
        if (reset || flush) begin
          state  <= OCC_EMPTY;
          main_q <= '0;
          skid_q <= '0;
        end else begin
          case (state)
            OCC_EMPTY: begin
              if (in_xfer) begin
                main_q <= in_data;
                state  <= OCC_ONE;
              end
            end
            OCC_ONE: begin
              if (in_xfer && out_xfer) begin
                main_q <= in_data;
              end else if (in_xfer) begin
                skid_q <= in_data;
                state  <= OCC_FULL;
              end else if (out_xfer) begin
                main_q <= '0;
                state  <= OCC_EMPTY;
              end
            end
            OCC_FULL: begin
              if (out_xfer) begin
                main_q <= skid_q;
                skid_q <= '0;
                state  <= OCC_ONE;
              end
            end
            default: begin
              state  <= OCC_EMPTY;
              main_q <= '0;
              skid_q <= '0;
            end
          endcase
        end
      end
    end else begin : g_flop
      logic             valid_q;
      logic [WIDTH-1:0] main_q;

      assign out_valid = valid_q;
      assign out_data  = main_q;
      assign in_ready  = ~valid_q | out_ready | flush;

      always_ff @(posedge clk) begin
        if (reset || flush) begin
          valid_q <= 1'b0;
          main_q  <= '0;
        end else if (in_xfer) begin
          valid_q <= 1'b1;
          main_q  <= in_data;
        end else if (out_xfer) begin
          valid_q <= 1'b0;
          main_q  <= '0;
        end
      end
    end
  endgenerate

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (out_valid & ~out_ready),
    .cnt   (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (~out_valid & out_ready),
    .cnt   (bubble_cnt)
  );

endmodule
